// File: rtl/m0_pkg.sv
// Shared types and constants for the m0 serial frame receiver.
// Optional even-parity trailer is enabled by defining M0_FRAME_PARITY_EN.
package m0_pkg;

  localparam int M0_FRAME_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1
`ifdef M0_FRAME_PARITY_EN
    ,
    ST_PARITY = 2'd2
`endif
  } m0_state_e;

endpackage

// File: rtl/m0_frame_hold.sv
// Output holding register with valid/ready handshake and overrun detection.
// Takes a one-cycle load strobe from the receiver FSM.
module m0_frame_hold #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             overrun
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (load) begin
      // A word still held and not taken this cycle wins; the new one is dropped.
      if (!valid_q || out_ready) begin
        data_d  = load_data;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign overrun   = overrun_q;

endmodule

// File: rtl/m0_frame_rx.sv
// Serial frame receiver: assembles WIDTH bits LSB-first into a word, with resync on frame_start.
// Defining M0_FRAME_PARITY_EN adds a trailing even-parity bit check.
module m0_frame_rx
  import m0_pkg::*;
#(
  parameter int WIDTH = M0_FRAME_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sin,
  input  logic             frame_start,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  m0_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             load;
  logic [WIDTH-1:0] load_data;
`ifdef M0_FRAME_PARITY_EN
  logic             parity_err_q, parity_err_d;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    load      = 1'b0;
    load_data = shift_q;
`ifdef M0_FRAME_PARITY_EN
    parity_err_d = 1'b0;
`endif
    if (en) begin
      if (frame_start) begin
        // Start from any state; a partial frame is simply abandoned.
        state_d    = ST_SHIFT;
        cnt_d      = CNT_W'(1);
        shift_d    = '0;
        shift_d[0] = sin;
      end else begin
        unique case (state_q)
          ST_SHIFT: begin
            for (int i = 0; i < WIDTH; i++) begin
              if (cnt_q == CNT_W'(i)) shift_d[i] = sin;
            end
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              cnt_d = '0;
`ifdef M0_FRAME_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d   = ST_IDLE;
              load      = 1'b1;
              load_data = shift_d;
`endif
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
`ifdef M0_FRAME_PARITY_EN
          ST_PARITY: begin
            state_d = ST_IDLE;
            if ((^shift_q) == sin) load = 1'b1;
            else                   parity_err_d = 1'b1;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments only; the shift register is reset
    // along with control so no stale partial frame survives rst.
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

`ifdef M0_FRAME_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) parity_err_q <= 1'b0;
    else     parity_err_q <= parity_err_d;
  end
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  m0_frame_hold #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .overrun   (overrun)
  );

endmodule
